ds_rx_downconverter: RTL and testbench
======================================

# ds_rx_downconverter

Receive-side counterpart of the CORDIC/delta-sigma transmit frequency generator. It takes a 1-bit delta-sigma bitstream from the receive comparator and mixes it with an internal square-wave quadrature LO. The LO is driven by the same 30-bit phase-increment word `f_c` the transmitter uses. The mixed I and Q streams are decimated by a 3rd-order CIC at the same OSR set (32/64/128/256), producing 16-bit signed baseband I/Q samples with a valid strobe for the RISC-V side.

## Interface
- Parameters: none. Widths are fixed constants in the package.
- `clk` in 1: single clock; `ds_in` is sampled on every rising edge.
- `reset_n` in 1: reset is synchronous and active-low.
- `f_c` in 30: NCO phase increment per clk; sampled at `start`.
- `osr_level` in 2: decimation ratio R, where 0→32, 1→64, 2→128, 3→256; sampled at `start`.
- `start` in 1: one-cycle request to begin reception; ignored unless IDLE.
- `stop` in 1: request to end reception; ignored in IDLE.
- `ds_in` in 1: comparator bitstream; 1 maps to +1, 0 maps to −1.
- `active` out 1: high in any state other than IDLE.
- `sample_valid` out 1: one-cycle pulse when a new `i_out`/`q_out` pair is presented.
- `i_out` out 16: signed I sample; held until the next valid.
- `q_out` out 16: signed Q sample; held until the next valid.
- `overflow` out 1: sticky; set when any output saturates; cleared by reset or by `start`.

## Operation
- State machine: IDLE → SETTLE → RUN → IDLE.
  - IDLE + `start`: latch `f_c` and R; clear phase, integrators, comb delays, decimation counter and `overflow`; go to SETTLE.
  - SETTLE: discard the first 3 decimated outputs (no `sample_valid`); move to RUN at the 3rd tick.
  - RUN: every decimation tick produces a valid output.
  - `stop` in SETTLE or RUN: set a stop-pending flag and go to IDLE at the next decimation tick. The sample computed on that tick is still emitted if in RUN.
  - `start` outside IDLE is ignored.
- NCO: 30-bit accumulator `phase`, which wraps modulo 2^30. Quadrant q = `phase[29:28]`.
  - `lo_i` = +1 for q ∈ {0,3}, −1 for q ∈ {1,2}.
  - `lo_q` = +1 for q ∈ {0,1}, −1 for q ∈ {2,3}.
- Mixer: `mix_i` = `ds_in`·`lo_i` and `mix_q` = `ds_in`·`lo_q`, each ±1.
- CIC per channel: 3 integrators and 3 combs (differential delay 1), all 26-bit two's complement. Integrators wrap; modular arithmetic makes this exact. Full-scale output is ±R^3 (at most 2^24).
- Scaling: `out` = `cic` >>> (3·(5+`osr_level`) − 15), i.e. shift 0/3/6/9.
  - Saturate to [−32768, +32767]; any saturation sets `overflow`.
- In IDLE, integrators, counter and phase are frozen; `i_out`/`q_out` hold their last value.

## Timing
- Reset values: `active`=0, `sample_valid`=0, `i_out`=0, `q_out`=0, `overflow`=0, state=IDLE, phase=0.
- `start` is sampled in cycle 0. The first mixed sample (phase=0) enters the integrators in cycle 1; phase advances by `f_c` every cycle thereafter.
- Decimation tick k occurs on the cycle in which the k-th block of R inputs completes (cycle k·R). Combs and scaling are evaluated on the tick, and `sample_valid` pulses at cycle k·R+1.
- Ticks 1–3 are discarded, so the first `sample_valid` is at cycle 4R+1 (129 at R=32).
- `active` rises in cycle 1 and falls the cycle after the terminating tick.
- If `stop` and a tick coincide, that tick terminates.
- `reset_n` low mid-operation: everything returns to reset values on the next edge, and any pending `sample_valid` is lost.

## Configuration
- `RX_DC_BLOCK_EN` defined: insert a first-order DC-removal filter per channel after scaling, updated only on valid samples.
  - y[n] = x[n] − x[n−1] + y[n−1] − (y[n−1] >>> 8).
  - 24-bit internal state, saturated to 16 bits. State is cleared on `start`.
  - Adds no cycle latency; it is computed combinationally in the tick cycle.
- Not defined: `i_out`/`q_out` are the scaled, saturated CIC outputs directly.

## Structure
- Shared package `rx_pkg`:
  - State enum `rx_state_t` (IDLE, SETTLE, RUN).
  - `PHASE_W`=30, `CIC_W`=26, `OUT_W`=16, `CIC_ORDER`=3.
  - Function mapping `osr_level` to R−1 and to the scaling shift.
- One sub-module, `cic_decim3`: a single channel, instantiated twice. It owns the integrators, combs and scaling/saturation. Inputs are the ±1 sample, the tick and the shift; outputs are the 16-bit value and a saturate flag.
- The top level owns the FSM, NCO, mixer, decimation counter and the optional DC block.

## Test plan
- Bench default: `RX_DC_BLOCK_EN` undefined.
- `f_c`=0, `osr_level`=0, `ds_in` pattern 1,1,1,0 repeating → first `sample_valid` at cycle 129; `i_out`=`q_out`=16384 on every sample; `overflow`=0.
- `f_c`=2^28, `osr_level`=0, `ds_in`=1,0,0,1 repeating, aligned to cycle 1 → `i_out`=32767, `q_out`=0, `overflow`=1.
- `f_c`=0, `osr_level`=3, `ds_in` alternating 1/0 → `i_out`=`q_out`=0; first valid at cycle 1025.
- `stop` pulsed in RUN mid-block at R=64 → exactly one more `sample_valid` at the next tick+1, then `active`=0. `start` during RUN is ignored.
- `reset_n` low for 1 cycle during SETTLE → all outputs 0 and state IDLE. A new `start` gives the first valid exactly 4R+1 cycles later.
- With `RX_DC_BLOCK_EN` defined: constant `ds_in`=1 with `f_c`=0 → the output magnitude decays monotonically toward 0 over successive samples.

Source files
------------

// File: rtl/rx_pkg.sv
// Shared definitions for the delta-sigma receive downconverter: widths,
// FSM state encoding, decimation-ratio decoding and saturation helpers.
package rx_pkg;

    localparam int PHASE_W   = 30;
    localparam int CIC_W     = 26;
    localparam int OUT_W     = 16;
    localparam int CIC_ORDER = 3;
    localparam int CNT_W     = 8;
    localparam int SHIFT_W   = 4;
    localparam int DC_W      = 24;

    // Index of the last discarded decimation tick while the CIC settles.
    localparam logic [1:0] SETTLE_LAST = 2'(CIC_ORDER - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        RUN    = 2'd2
    } rx_state_t;

    // Decimation ratio minus one, used as the terminal count of the block counter.
    function automatic logic [CNT_W-1:0] osr_to_rm1(input logic [1:0] lvl);
        case (lvl)
            2'd0:    return 8'd31;
            2'd1:    return 8'd63;
            2'd2:    return 8'd127;
            2'd3:    return 8'd255;
            default: return 8'd31;
        endcase
    endfunction

    // Right shift that maps full-scale R^3 onto the 16-bit output range.
    function automatic logic [SHIFT_W-1:0] osr_to_shift(input logic [1:0] lvl);
        case (lvl)
            2'd0:    return 4'd0;
            2'd1:    return 4'd3;
            2'd2:    return 4'd6;
            2'd3:    return 4'd9;
            default: return 4'd0;
        endcase
    endfunction

    // Clamp a wide two's-complement value into the 16-bit signed output range.
    function automatic logic [OUT_W-1:0] sat_out(input logic signed [CIC_W-1:0] v);
        if (v > 26'sd32767) begin
            return 16'h7FFF;
        end else if (v < -26'sd32768) begin
            return 16'h8000;
        end else begin
            return v[OUT_W-1:0];
        end
    endfunction

    // Flag that sat_out would clamp this value.
    function automatic logic is_sat_out(input logic signed [CIC_W-1:0] v);
        return (v > 26'sd32767) || (v < -26'sd32768);
    endfunction

    // Clamp a wide value into the 24-bit DC-removal state range.
    function automatic logic [DC_W-1:0] sat_dc(input logic signed [CIC_W-1:0] v);
        if (v > 26'sd8388607) begin
            return 24'h7FFFFF;
        end else if (v < -26'sd8388608) begin
            return 24'h800000;
        end else begin
            return v[DC_W-1:0];
        end
    endfunction

    // One step of y[n] = x[n] - x[n-1] + y[n-1] - (y[n-1] >>> 8), saturated to 24 bits.
    function automatic logic [DC_W-1:0] dc_next(input logic [OUT_W-1:0] x,
                                                input logic [OUT_W-1:0] x1,
                                                input logic [DC_W-1:0]  y1);
        logic signed [CIC_W-1:0] acc;
        acc = {{10{x[15]}}, x} - {{10{x1[15]}}, x1}
            + {{2{y1[23]}}, y1} - {{10{y1[23]}}, y1[23:8]};
        return sat_dc(acc);
    endfunction

endpackage

// File: rtl/cic_decim3.sv
// Single-channel 3rd-order CIC decimator (differential delay 1) fed with a
// +/-1 sample. Integrators run every enabled cycle and wrap modulo 2^26;
// the comb chain, scaling and saturation are evaluated combinationally on
// the decimation tick so the caller can register the result on that edge.
module cic_decim3
    import rx_pkg::*;
(
    input  logic               clk,
    input  logic               reset_n,
    input  logic               clr,
    input  logic               en,
    input  logic               sample_pos,
    input  logic               tick,
    input  logic [SHIFT_W-1:0] shift,
    output logic [OUT_W-1:0]   value,
    output logic               sat
);

    logic signed [CIC_W-1:0] int1_r, int2_r, int3_r;
    logic signed [CIC_W-1:0] dly1_r, dly2_r, dly3_r;
    logic signed [CIC_W-1:0] x_s, int1_n_s, int2_n_s, int3_n_s;
    logic signed [CIC_W-1:0] comb1_s, comb2_s, comb3_s, scaled_s;

    // Integrator update including the current sample, then comb, scale and clamp.
    always_comb begin
        x_s      = 26'sd1;
        if (sample_pos) begin
            x_s = 26'sd1;
        end else begin
            x_s = -26'sd1;
        end
        int1_n_s = int1_r + x_s;
        int2_n_s = int2_r + int1_n_s;
        int3_n_s = int3_r + int2_n_s;
        comb1_s  = int3_n_s - dly1_r;
        comb2_s  = comb1_s - dly2_r;
        comb3_s  = comb2_s - dly3_r;
        scaled_s = comb3_s >>> shift;
        value    = sat_out(scaled_s);
        sat      = is_sat_out(scaled_s);
    end

    // Integrator and comb-delay registers; cleared by reset or a new reception.
    always_ff @(posedge clk) begin
        if (!reset_n || clr) begin
            int1_r <= 26'sd0;
            int2_r <= 26'sd0;
            int3_r <= 26'sd0;
            dly1_r <= 26'sd0;
            dly2_r <= 26'sd0;
            dly3_r <= 26'sd0;
        end else if (en) begin
            int1_r <= int1_n_s;
            int2_r <= int2_n_s;
            int3_r <= int3_n_s;
            if (tick) begin
                dly1_r <= int3_n_s;
                dly2_r <= comb1_s;
                dly3_r <= comb2_s;
            end
        end
    end

endmodule

// File: rtl/ds_rx_downconverter.sv
// Delta-sigma receive downconverter: square-wave quadrature NCO, +/-1 mixer,
// two CIC decimators and the IDLE/SETTLE/RUN control sequence.
// Optional feature macro: RX_DC_BLOCK_EN adds a first-order DC-removal
// filter per channel on the emitted samples.
module ds_rx_downconverter
    import rx_pkg::*;
(
    input  logic               clk,
    input  logic               reset_n,
    input  logic [PHASE_W-1:0] f_c,
    input  logic [1:0]         osr_level,
    input  logic               start,
    input  logic               stop,
    input  logic               ds_in,
    output logic               active,
    output logic               sample_valid,
    output logic [OUT_W-1:0]   i_out,
    output logic [OUT_W-1:0]   q_out,
    output logic               overflow
);

    rx_state_t          state_r, state_n_s;
    logic [PHASE_W-1:0] f_c_r, phase_r;
    logic [CNT_W-1:0]   rm1_r, cnt_r;
    logic [SHIFT_W-1:0] shift_r;
    logic [1:0]         settle_cnt_r;
    logic               stop_pend_r;

    logic               run_s, tick_s, clr_s, stop_hit_s, emit_s;
    logic [1:0]         quad_s;
    logic               mix_i_pos_s, mix_q_pos_s;
    logic [OUT_W-1:0]   cic_i_s, cic_q_s, out_i_s, out_q_s;
    logic               sat_i_s, sat_q_s, sat_any_s;

    // Control strobes derived from the current state and block counter.
    always_comb begin
        run_s      = (state_r != IDLE);
        tick_s     = run_s && (cnt_r == rm1_r);
        clr_s      = (state_r == IDLE) && start;
        stop_hit_s = tick_s && (stop || stop_pend_r);
        emit_s     = tick_s && (state_r == RUN);
    end

    // Square-wave LO from the NCO quadrant; mixing two +/-1 values is an XNOR.
    always_comb begin
        quad_s      = phase_r[PHASE_W-1 -: 2];
        mix_i_pos_s = ~(ds_in ^ ~(quad_s[1] ^ quad_s[0]));
        mix_q_pos_s = ~(ds_in ^ ~quad_s[1]);
    end

    // Next-state logic: three ticks to settle, any tick after a stop ends reception.
    always_comb begin
        state_n_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_n_s = SETTLE;
                end else begin
                    state_n_s = IDLE;
                end
            end
            SETTLE: begin
                if (stop_hit_s) begin
                    state_n_s = IDLE;
                end else if (tick_s && (settle_cnt_r == SETTLE_LAST)) begin
                    state_n_s = RUN;
                end else begin
                    state_n_s = SETTLE;
                end
            end
            RUN: begin
                if (stop_hit_s) begin
                    state_n_s = IDLE;
                end else begin
                    state_n_s = RUN;
                end
            end
            default: state_n_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_n_s;
        end
    end

    // Configuration latch, NCO phase, block counter, settle counter and stop request.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            f_c_r        <= 30'd0;
            rm1_r        <= 8'd31;
            shift_r      <= 4'd0;
            phase_r      <= 30'd0;
            cnt_r        <= 8'd0;
            settle_cnt_r <= 2'd0;
            stop_pend_r  <= 1'b0;
        end else if (clr_s) begin
            f_c_r        <= f_c;
            rm1_r        <= osr_to_rm1(osr_level);
            shift_r      <= osr_to_shift(osr_level);
            phase_r      <= 30'd0;
            cnt_r        <= 8'd0;
            settle_cnt_r <= 2'd0;
            stop_pend_r  <= 1'b0;
        end else if (run_s) begin
            phase_r <= phase_r + f_c_r;
            if (tick_s) begin
                cnt_r <= 8'd0;
            end else begin
                cnt_r <= cnt_r + 8'd1;
            end
            if (tick_s && (state_r == SETTLE)) begin
                settle_cnt_r <= settle_cnt_r + 2'd1;
            end
            if (stop_hit_s) begin
                stop_pend_r <= 1'b0;
            end else if (stop) begin
                stop_pend_r <= 1'b1;
            end
        end
    end

    cic_decim3 u_cic_i (
        .clk        (clk),
        .reset_n    (reset_n),
        .clr        (clr_s),
        .en         (run_s),
        .sample_pos (mix_i_pos_s),
        .tick       (tick_s),
        .shift      (shift_r),
        .value      (cic_i_s),
        .sat        (sat_i_s)
    );

    cic_decim3 u_cic_q (
        .clk        (clk),
        .reset_n    (reset_n),
        .clr        (clr_s),
        .en         (run_s),
        .sample_pos (mix_q_pos_s),
        .tick       (tick_s),
        .shift      (shift_r),
        .value      (cic_q_s),
        .sat        (sat_q_s)
    );

`ifdef RX_DC_BLOCK_EN
    logic [OUT_W-1:0] x1_i_r, x1_q_r;
    logic [DC_W-1:0]  y1_i_r, y1_q_r, y_i_s, y_q_s;

    // DC-removal step on the tick, feeding the output register in the same cycle.
    always_comb begin
        y_i_s     = dc_next(cic_i_s, x1_i_r, y1_i_r);
        y_q_s     = dc_next(cic_q_s, x1_q_r, y1_q_r);
        out_i_s   = sat_out({{2{y_i_s[23]}}, y_i_s});
        out_q_s   = sat_out({{2{y_q_s[23]}}, y_q_s});
        sat_any_s = sat_i_s || sat_q_s
                 || is_sat_out({{2{y_i_s[23]}}, y_i_s})
                 || is_sat_out({{2{y_q_s[23]}}, y_q_s});
    end

    // DC filter history, advanced only on emitted samples.
    always_ff @(posedge clk) begin
        if (!reset_n || clr_s) begin
            x1_i_r <= 16'd0;
            x1_q_r <= 16'd0;
            y1_i_r <= 24'd0;
            y1_q_r <= 24'd0;
        end else if (emit_s) begin
            x1_i_r <= cic_i_s;
            x1_q_r <= cic_q_s;
            y1_i_r <= y_i_s;
            y1_q_r <= y_q_s;
        end
    end
`else
    // Scaled CIC outputs go straight to the output register.
    always_comb begin
        out_i_s   = cic_i_s;
        out_q_s   = cic_q_s;
        sat_any_s = sat_i_s || sat_q_s;
    end
`endif

    // Registered outputs: status, valid strobe, held samples and sticky overflow.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            active       <= 1'b0;
            sample_valid <= 1'b0;
            i_out        <= 16'd0;
            q_out        <= 16'd0;
            overflow     <= 1'b0;
        end else begin
            active       <= (state_n_s != IDLE);
            sample_valid <= emit_s;
            if (emit_s) begin
                i_out <= out_i_s;
                q_out <= out_q_s;
            end
            if (clr_s) begin
                overflow <= 1'b0;
            end else if (emit_s && sat_any_s) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ds_rx_downconverter.sv
// Directed testbench for ds_rx_downconverter (default build, no DC block).
// Cycle numbering: the edge that samples start is edge 0; values observed
// just after edge m belong to cycle m+1.
`timescale 1ns/1ps
module tb_ds_rx_downconverter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [29:0] f_c;
    logic [1:0]  osr_level;
    logic        start;
    logic        stop;
    logic        ds_in;
    logic        active;
    logic        sample_valid;
    logic [15:0] i_out;
    logic [15:0] q_out;
    logic        overflow;

    int          n_checks = 0;
    int          n_errors = 0;
    int          edge_n   = 0;
    logic [3:0]  pat      = 4'b0000;

    ds_rx_downconverter dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .f_c          (f_c),
        .osr_level    (osr_level),
        .start        (start),
        .stop         (stop),
        .ds_in        (ds_in),
        .active       (active),
        .sample_valid (sample_valid),
        .i_out        (i_out),
        .q_out        (q_out),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One clock: drive the pattern bit for the coming edge, then sample after it.
    task automatic step();
        @(negedge clk);
        ds_in = pat[edge_n[1:0]];
        @(posedge clk);
        edge_n++;
        #1;
    endtask

    task automatic do_start(input logic [29:0] fc, input logic [1:0] lvl, input logic [3:0] p);
        @(negedge clk);
        f_c       = fc;
        osr_level = lvl;
        pat       = p;
        start     = 1'b1;
        @(posedge clk);
        edge_n = 0;
        #1;
        start = 1'b0;
    endtask

    // Step until sample_valid is seen; cyc = -1 if the budget runs out.
    task automatic wait_valid(input int limit, output int cyc);
        cyc = -1;
        for (int i = 0; i < limit; i++) begin
            step();
            if (sample_valid) begin
                cyc = edge_n + 1;
                break;
            end
        end
    endtask

    task automatic stop_to_idle(input string tag);
        int fell;
        fell = 0;
        stop = 1'b1;
        step();
        stop = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (!active) begin
                fell = 1;
                break;
            end
            step();
        end
        check_val(tag, fell, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c;
        int nv;
        int vcyc;
        int fall;

        reset_n   = 1'b0;
        start     = 1'b0;
        stop      = 1'b0;
        ds_in     = 1'b0;
        f_c       = 30'd0;
        osr_level = 2'd0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_active", int'(active), 0);
        check_val("rst_valid", int'(sample_valid), 0);
        check_val("rst_i", $signed(i_out), 0);
        check_val("rst_q", $signed(q_out), 0);
        check_val("rst_ovf", int'(overflow), 0);
        @(negedge clk);
        reset_n = 1'b1;

        // Half-scale DC at R=32: 0.5 * 32^3 = 16384 on both channels.
        do_start(30'd0, 2'd0, 4'b0111);
        check_val("t1_active_rise", int'(active), 1);
        wait_valid(200, c);
        check_val("t1_first_valid", c, 129);
        check_val("t1_i", $signed(i_out), 16384);
        check_val("t1_q", $signed(q_out), 16384);
        check_val("t1_ovf", int'(overflow), 0);
        for (int k = 1; k <= 2; k++) begin
            wait_valid(40, c);
            check_val("t1_next_valid", c, 129 + 32 * k);
            check_val("t1_i_next", $signed(i_out), 16384);
            check_val("t1_q_next", $signed(q_out), 16384);
        end
        stop_to_idle("t1_idle");

        // LO at clk/4 matched to the input: I full scale saturates, Q cancels.
        do_start(30'h1000_0000, 2'd0, 4'b1001);
        wait_valid(200, c);
        check_val("t2_first_valid", c, 129);
        check_val("t2_i_sat", $signed(i_out), 32767);
        check_val("t2_q_zero", $signed(q_out), 0);
        check_val("t2_ovf", int'(overflow), 1);
        stop_to_idle("t2_idle");
        check_val("t2_ovf_sticky", int'(overflow), 1);

        // R=256 with zero-mean input; start must clear the sticky overflow.
        do_start(30'd0, 2'd3, 4'b0101);
        check_val("t3_ovf_cleared", int'(overflow), 0);
        wait_valid(1100, c);
        check_val("t3_first_valid", c, 1025);
        check_val("t3_i", $signed(i_out), 0);
        check_val("t3_q", $signed(q_out), 0);
        stop_to_idle("t3_idle");

        // R=64: shift 3 gives 2^17 >>> 3 = 16384; start in RUN ignored; stop mid-block.
        do_start(30'd0, 2'd1, 4'b0111);
        wait_valid(300, c);
        check_val("t4_first_valid", c, 257);
        check_val("t4_i", $signed(i_out), 16384);
        repeat (9) step();
        start = 1'b1;
        step();
        start = 1'b0;
        check_val("t4_start_ignored", int'(active), 1);
        while (edge_n < 280) step();
        stop = 1'b1;
        step();
        stop = 1'b0;
        nv   = 0;
        vcyc = -1;
        fall = -1;
        for (int i = 0; i < 100; i++) begin
            step();
            if (sample_valid) begin
                nv++;
                vcyc = edge_n + 1;
            end
            if (!active) begin
                fall = edge_n + 1;
                break;
            end
        end
        check_val("t4_last_valid_cycle", vcyc, 321);
        check_val("t4_active_fall", fall, 321);
        check_val("t4_last_i", $signed(i_out), 16384);
        repeat (5) begin
            step();
            if (sample_valid) nv++;
        end
        check_val("t4_valid_count", nv, 1);
        check_val("t4_i_held", $signed(i_out), 16384);

        // Reset during SETTLE, then a fresh start.
        do_start(30'd0, 2'd0, 4'b0111);
        repeat (50) step();
        @(negedge clk);
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        check_val("t5_active", int'(active), 0);
        check_val("t5_valid", int'(sample_valid), 0);
        check_val("t5_i", $signed(i_out), 0);
        check_val("t5_q", $signed(q_out), 0);
        check_val("t5_ovf", int'(overflow), 0);
        @(negedge clk);
        reset_n = 1'b1;
        step();
        check_val("t5_still_idle", int'(active), 0);
        do_start(30'd0, 2'd0, 4'b0111);
        wait_valid(200, c);
        check_val("t5_first_valid", c, 129);
        check_val("t5_i_after", $signed(i_out), 16384);
        stop_to_idle("t5_idle");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
